// File: rtl/crc_pkg.sv
// Shared types, default polynomials and the single-bit CRC step for crc_stream.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } crc_state_e;

  localparam int CRC_MAX_W = 32;

  localparam logic [7:0] CRC8_POLY_X8P1  = 8'h01;
  localparam logic [7:0] CRC8_SMBUS_POLY = 8'h07;

  // mask selects the live low bits; its top set bit is the register MSB
  function automatic logic [CRC_MAX_W-1:0] crc_bit(
    input logic [CRC_MAX_W-1:0] c,
    input logic                 d,
    input logic [CRC_MAX_W-1:0] poly,
    input logic [CRC_MAX_W-1:0] mask
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] top;
    top     = mask & ~(mask >> 1);
    fb      = (|(c & top)) ^ d;
    crc_bit = ((c << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update over one beat, MSB of the beat first.
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 80,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY_X8P1)
) (
  input  logic [CRC_W-1:0]  c,
  input  logic [DATA_W-1:0] d,
  output logic [CRC_W-1:0]  nxt
);

  localparam logic [CRC_MAX_W-1:0] MASK =
    {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - CRC_W);
  localparam logic [CRC_MAX_W-1:0] POLY_X = CRC_MAX_W'(POLY);

  logic [CRC_MAX_W-1:0] t;

  always_comb begin
    t = CRC_MAX_W'(c);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      t = crc_bit(t, d[i], POLY_X, MASK);
    end
    nxt = t[CRC_W-1:0];
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC with valid/ready on beats and result; define
// CRC_STREAM_CHECK_EN to add the chk_data compare and crc_err flag.
module crc_stream
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter int               DATA_W  = 80,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY_X8P1),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOR_OUT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out
`ifdef CRC_STREAM_CHECK_EN
  ,
  input  logic [CRC_W-1:0]  chk_data,
  output logic              crc_err
`endif
);

  crc_state_e       state;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] nxt;
  logic [CRC_W-1:0] fin;
  logic             accept;
  logic             take;

  assign in_ready = !crc_valid || crc_ready;
  assign accept   = in_valid && in_ready;
  assign take     = crc_valid && crc_ready;

  // anything outside ACCUM, or an explicit sop, opens a fresh frame
  assign base = (in_sop || state != ACCUM) ? INIT : crc_q;
  assign fin  = nxt ^ XOR_OUT;

  crc_step #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W),
    .POLY  (POLY)
  ) u_step (
    .c  (base),
    .d  (in_data),
    .nxt(nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_q     <= INIT;
      crc_out   <= '0;
      crc_valid <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
      crc_err   <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        accept && in_last: begin
          state     <= HOLD;
          crc_q     <= INIT;
          crc_out   <= fin;
          crc_valid <= 1'b1;
`ifdef CRC_STREAM_CHECK_EN
          crc_err   <= fin != chk_data;
`endif
        end
        accept && !in_last: begin
          state     <= ACCUM;
          crc_q     <= nxt;
          crc_valid <= 1'b0;
        end
        !accept && take: begin
          state     <= IDLE;
          crc_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench: default X^8+1 instance plus an 8-bit SMBus CRC instance.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v0 = 0, sop0 = 0, last0 = 0, rdy0 = 1;
  logic [79:0] d0 = '0;
  logic        ir0, cv0;
  logic [7:0]  co0;

  logic        v1 = 0, sop1 = 0, last1 = 0, rdy1 = 1;
  logic [7:0]  d1 = '0;
  logic        ir1, cv1;
  logic [7:0]  co1;
  logic [7:0]  chk1 = '0;
`ifdef CRC_STREAM_CHECK_EN
  logic        err0, err1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  crc_stream u_d0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v0),
    .in_ready (ir0),
    .in_sop   (sop0),
    .in_last  (last0),
    .in_data  (d0),
    .crc_valid(cv0),
    .crc_ready(rdy0),
    .crc_out  (co0)
`ifdef CRC_STREAM_CHECK_EN
    ,
    .chk_data (8'h00),
    .crc_err  (err0)
`endif
  );

  crc_stream #(
    .CRC_W  (8),
    .DATA_W (8),
    .POLY   (8'h07),
    .INIT   (8'h00),
    .XOR_OUT(8'h00)
  ) u_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v1),
    .in_ready (ir1),
    .in_sop   (sop1),
    .in_last  (last1),
    .in_data  (d1),
    .crc_valid(cv1),
    .crc_ready(rdy1),
    .crc_out  (co1)
`ifdef CRC_STREAM_CHECK_EN
    ,
    .chk_data (chk1),
    .crc_err  (err1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic beat0(input logic s, input logic l, input logic [79:0] d);
    @(negedge clk);
    v0 = 1; sop0 = s; last0 = l; d0 = d;
    @(posedge clk);
    #1;
    v0 = 0; sop0 = 0; last0 = 0;
  endtask

  task automatic beat1(input logic s, input logic l, input logic [7:0] d,
                       input logic [7:0] c);
    @(negedge clk);
    v1 = 1; sop1 = s; last1 = l; d1 = d; chk1 = c;
    @(posedge clk);
    #1;
    v1 = 0; sop1 = 0; last1 = 0;
  endtask

  task automatic frame1(input logic s, input logic [7:0] c);
    string msg;
    msg = "123456789";
    for (int i = 0; i < 9; i++) begin
      beat1(s && i == 0, i == 8, msg[i], c);
    end
  endtask

  initial begin
    #2;
    check("rst_cv0", 32'(cv0), 32'd0);
    check("rst_co0", 32'(co0), 32'h00);
    check("rst_cv1", 32'(cv1), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 32'(ir0), 32'd1);

    beat0(1, 1, 80'h0);
    check("zero_cv", 32'(cv0), 32'd1);
    check("zero_co", 32'(co0), 32'h00);
    beat0(1, 1, 80'h1);
    check("one_co", 32'(co0), 32'h01);
    beat0(1, 1, 80'h0102);
    check("0102_co", 32'(co0), 32'h03);

    frame1(1, 8'hF4);
    check("smbus_cv", 32'(cv1), 32'd1);
    check("smbus_co", 32'(co1), 32'hF4);
`ifdef CRC_STREAM_CHECK_EN
    check("err_good", 32'(err1), 32'd0);
    frame1(1, 8'hF5);
    check("err_bad", 32'(err1), 32'd1);
`endif

    // Stalled result must hold; offered beats are not taken
    rdy0 = 0;
    beat0(1, 1, 80'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v0 = 1; sop0 = 1; last0 = 1; d0 = 80'h0;
      check("bp_co", 32'(co0), 32'h01);
      check("bp_cv", 32'(cv0), 32'd1);
      check("bp_ir", 32'(ir0), 32'd0);
    end
    @(negedge clk);
    rdy0 = 1; v0 = 1; sop0 = 1; last0 = 1; d0 = 80'h0102;
    @(posedge clk);
    #1;
    v0 = 0; sop0 = 0; last0 = 0;
    check("bp_new_cv", 32'(cv0), 32'd1);
    check("bp_new_co", 32'(co0), 32'h03);

    for (int i = 0; i < 3; i++) begin
      beat1(i == 0, 0, 8'h41 + 8'(i), 8'h00);
    end
    frame1(1, 8'hF4);
    check("restart_co", 32'(co1), 32'hF4);

    rdy0 = 0;
    beat0(1, 1, 80'h1);
    for (int i = 0; i < 3; i++) begin
      beat1(i == 0, 0, 8'h31 + 8'(i), 8'h00);
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_hold_cv0", 32'(cv0), 32'd0);
    check("rst_mid_cv1", 32'(cv1), 32'd0);
    rdy0 = 1;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    check("no_result_cv1", 32'(cv1), 32'd0);
    check("no_result_cv0", 32'(cv0), 32'd0);

    frame1(0, 8'hF4);
    check("nosop_co", 32'(co1), 32'hF4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CRC_W SHALL default to 8 and set the CRC register width.
REQ-003 Parameter DATA_W SHALL default to 80 and set the data bits per beat.
REQ-004 Parameter POLY SHALL default to 'h01 and give the generator polynomial, implicit top bit omitted; 'h01 means x^8+1.
REQ-005 Parameter INIT SHALL default to all-ones and give the register preset at start of frame.
REQ-006 Parameter XOR_OUT SHALL default to all-ones and be XORed onto the final register value.
REQ-007 Ports:
  clk        in   1        clock, rising edge
  rst_n      in   1        async active-low reset
  in_valid   in   1        beat present
  in_ready   out  1        block accepts beat
  in_sop     in   1        beat is first of frame
  in_last    in   1        beat is last of frame
  in_data    in   DATA_W   beat data, first serial bit in_data[DATA_W-1]
  crc_valid  out  1        result present
  crc_ready  in   1        consumer takes result
  crc_out    out  CRC_W    frame CRC

Function
REQ-008 A beat SHALL be accepted when in_valid && in_ready is high on a rising clk edge.
REQ-009 Per beat, the block SHALL process DATA_W bits MSB-first, each in one combinational step: fb = c[CRC_W-1]^d; c = (c<<1) ^ (fb ? POLY : 0).
REQ-010 The state machine SHALL have states IDLE, ACCUM and HOLD.
REQ-011 IDLE: an accepted beat with in_sop SHALL start from INIT; an accepted beat without in_sop SHALL also be treated as start of frame.
REQ-012 IDLE/ACCUM to ACCUM: on an accepted beat without in_last, the register SHALL be updated.
REQ-013 Any state to HOLD: on an accepted beat with in_last, crc_out SHALL equal final ^ XOR_OUT and crc_valid SHALL rise on the next cycle (latency 1 cycle from the last beat).
REQ-014 An accepted beat with in_sop in ACCUM SHALL discard the partial frame and restart from INIT.
REQ-015 A single beat with in_sop and in_last SHALL form a complete one-beat frame.
REQ-016 HOLD: crc_out and crc_valid SHALL stay stable until crc_ready is high.
REQ-017 HOLD: in_ready SHALL be low while crc_valid && !crc_ready.
REQ-018 in_ready = !crc_valid || crc_ready: a new beat accepted in the same cycle the result is taken SHALL be processed, with no bubble.
REQ-019 HOLD exit with no new beat SHALL go to IDLE; with a new non-last beat it SHALL go to ACCUM; with a new last beat it SHALL stay in HOLD with the new result.
REQ-020 The block SHALL ignore in_sop, in_last and in_data unless the beat is accepted.

Reset
REQ-021 While rst_n is low: state SHALL be IDLE, the register SHALL equal INIT, crc_out SHALL be 0 and crc_valid SHALL be 0.
REQ-022 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-023 Reset mid-frame or in HOLD SHALL discard the frame and the pending result without emitting a result.

Configuration
REQ-024 With macro CRC_STREAM_CHECK_EN defined:
  - input chk_data[CRC_W-1:0] SHALL be sampled with the last beat.
  - output crc_err SHALL be valid alongside crc_valid and high iff crc_out != chk_data.
  - crc_err SHALL reset to 0.
REQ-025 Without CRC_STREAM_CHECK_EN: chk_data and crc_err SHALL be absent and no compare logic SHALL exist.

Structure
REQ-026 Package crc_pkg SHALL hold:
  - the state enum typedef
  - default constants: CRC8_POLY_X8P1='h01, CRC8_SMBUS_POLY='h07
  - a function to compute one bit step
REQ-027 Sub-module crc_step SHALL be purely combinational, take (c, d) and return the post-beat register, parametrised by CRC_W, DATA_W and POLY.
REQ-028 The top module SHALL hold the FSM, handshake and output registers.

Verification
REQ-029 Defaults; one beat in_data=0 with sop+last -> crc_out=8'h00 next cycle, crc_valid=1.
REQ-030 Defaults; one beat in_data=80'h1 -> crc_out=8'h01; in_data=80'h0102 -> 8'h03.
REQ-031 CRC_W=8, DATA_W=8, POLY='h07, INIT=0, XOR_OUT=0; bytes "123456789" over 9 beats -> crc_out=8'hF4.
REQ-032 Backpressure: crc_ready=0 for 5 cycles -> crc_out stable, in_ready=0; crc_ready=1 with a new sop beat in the same cycle -> beat accepted, next result correct.
REQ-033 sop mid-frame after 3 beats -> result equals the new frame alone; rst_n low mid-frame -> crc_valid=0, no result.
REQ-034 CRC_STREAM_CHECK_EN; "123456789" with chk_data=8'hF4 -> crc_err=0; with chk_data=8'hF5 -> crc_err=1.
